// File: rtl/step_motor_ctrl.sv
// N-phase stepper sequencer: full/half-step beat generation with
// programmable step period and counted moves.
module step_motor_ctrl #(
    parameter int PHASES = 3,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 16,
    localparam int IDX_W = $clog2(2 * PHASES)
) (
    input  logic              CP,
    input  logic              CR,
    input  logic              en,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  steps,
    output logic [PHASES-1:0] phase,
    output logic [IDX_W-1:0]  idx,
    output logic              step_pulse,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W:0] BEATS = (IDX_W + 1)'(2 * PHASES);

    logic [DIV_W-1:0] presc;
    logic [CNT_W-1:0] remaining;
    logic             tick;
    logic             start_ok;
    logic             last;
    logic [IDX_W:0]   delta;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx_next;

    // Even beats energise one coil, odd beats the two neighbours.
    function automatic logic [PHASES-1:0] beat(input logic [IDX_W-1:0] k);
        int lo;
        int hi;
        logic [PHASES-1:0] t;
        lo = int'(k >> 1);
        hi = (lo + 1 == PHASES) ? 0 : lo + 1;
        t  = '0;
        for (int j = 0; j < PHASES; j++)
            t[j] = (j == lo) || (k[0] && (j == hi));
        return t;
    endfunction

    assign tick     = busy && en && !abort && (presc == div);
    assign start_ok = start && !busy && !abort;
    assign last     = tick && (remaining == CNT_W'(1));

    always_comb begin
        delta = (IDX_W + 1)'(1);
        unique case (mode)
            2'd0:    delta = idx[0] ? (IDX_W + 1)'(1) : (IDX_W + 1)'(2);
            2'd1:    delta = idx[0] ? (IDX_W + 1)'(2) : (IDX_W + 1)'(1);
            2'd2:    delta = (IDX_W + 1)'(1);
            default: delta = '0;
        endcase
        if (dir) begin
            sum = {1'b0, idx} + delta;
            if (sum >= BEATS)
                sum = sum - BEATS;
        end else if ({1'b0, idx} < delta) begin
            sum = {1'b0, idx} + BEATS - delta;
        end else begin
            sum = {1'b0, idx} - delta;
        end
        idx_next = tick ? sum[IDX_W-1:0] : idx;
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            idx        <= '0;
            phase      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_pulse <= 1'b0;
            remaining  <= '0;
            presc      <= '0;
        end else begin
            idx        <= idx_next;
            phase      <= en ? beat(idx_next) : '0;
            step_pulse <= tick;
            done       <= last || (start_ok && (steps == '0));
            if (abort || !busy)
                presc <= '0;
            else if (en)
                presc <= tick ? '0 : presc + DIV_W'(1);
            if (abort) begin
                remaining <= '0;
                busy      <= 1'b0;
            end else if (start_ok) begin
                remaining <= steps;
                busy      <= (steps != '0);
            end else if (tick) begin
                remaining <= remaining - CNT_W'(1);
                if (last)
                    busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_step_motor_ctrl.sv
// Directed bench for step_motor_ctrl (PHASES=3) with hand-computed
// beat indices, coil patterns and pulse timing.
module tb_step_motor_ctrl;

    logic        CP;
    logic        CR;
    logic        en;
    logic        dir;
    logic [1:0]  mode;
    logic [15:0] div;
    logic        start;
    logic        abort;
    logic [15:0] steps;
    logic [2:0]  phase;
    logic [2:0]  idx;
    logic        step_pulse;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_bad;

    step_motor_ctrl #(.PHASES(3), .DIV_W(16), .CNT_W(16)) dut (
        .CP(CP), .CR(CR), .en(en), .dir(dir), .mode(mode),
        .div(div), .start(start), .abort(abort), .steps(steps),
        .phase(phase), .idx(idx), .step_pulse(step_pulse),
        .busy(busy), .done(done)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    int          exp_idx[7];
    logic [2:0]  exp_ph[7];
    int          pulses;
    int          dones;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        CR = 1'b1; en = 1'b0; dir = 1'b1; mode = 2'd2; div = '0;
        start = 1'b0; abort = 1'b0; steps = '0;
        #12;
        check("rst_phase", 32'(phase), 0);
        check("rst_idx", 32'(idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pulse", 32'(step_pulse), 0);
        CR = 1'b0;
        en = 1'b1;
        step();
        check("hold_phase", 32'(phase), 32'b001);

        // half-step forward, 7 steps at full rate
        exp_idx = '{1, 2, 3, 4, 5, 0, 1};
        exp_ph  = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011};
        steps = 16'd7; start = 1'b1;
        step();
        start = 1'b0;
        check("t1_busy", 32'(busy), 1);
        check("t1_idx0", 32'(idx), 0);
        for (int i = 0; i < 7; i++) begin
            step();
            check("t1_idx", 32'(idx), 32'(exp_idx[i]));
            check("t1_phase", 32'(phase), 32'(exp_ph[i]));
            check("t1_pulse", 32'(step_pulse), 1);
            check("t1_done", 32'(done), (i == 6) ? 1 : 0);
            check("t1_busy", 32'(busy), (i == 6) ? 0 : 1);
        end
        step();
        check("t1_idle_pulse", 32'(step_pulse), 0);
        check("t1_idle_done", 32'(done), 0);
        check("t1_idle_phase", 32'(phase), 32'b011);

        // two-phase reverse from idx 0: realign to 5, then 3, 1
        CR = 1'b1; #2; CR = 1'b0;
        step();
        check("t2_idx0", 32'(idx), 0);
        check("t2_ph0", 32'(phase), 32'b001);
        exp_idx[0] = 5; exp_idx[1] = 3; exp_idx[2] = 1;
        exp_ph[0] = 3'b101; exp_ph[1] = 3'b110; exp_ph[2] = 3'b011;
        dir = 1'b0; mode = 2'd1; steps = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_idx", 32'(idx), 32'(exp_idx[i]));
            check("t2_phase", 32'(phase), 32'(exp_ph[i]));
            check("t2_done", 32'(done), (i == 2) ? 1 : 0);
        end

        // div=3: steps 4 and 8 cycles after start
        dir = 1'b1; mode = 2'd2; div = 16'd3; steps = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            check("t3_pulse", 32'(step_pulse), (c == 4 || c == 8) ? 1 : 0);
            check("t3_busy", 32'(busy), (c < 8) ? 1 : 0);
            check("t3_done", 32'(done), (c == 8) ? 1 : 0);
        end
        check("t3_idx", 32'(idx), 3);

        // zero-step move
        div = '0; steps = '0; start = 1'b1;
        step();
        start = 1'b0;
        check("t4_done", 32'(done), 1);
        check("t4_busy", 32'(busy), 0);
        check("t4_idx", 32'(idx), 3);
        step();
        check("t4_done_clr", 32'(done), 0);

        // second start while busy must not reload
        div = 16'd1; steps = 16'd3; start = 1'b1;
        step();
        check("t4_busy2", 32'(busy), 1);
        steps = 16'd9;
        step();
        start = 1'b0;
        pulses = 0; dones = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            pulses += int'(step_pulse);
            dones  += int'(done);
        end
        check("t4_pulses", 32'(pulses), 3);
        check("t4_dones", 32'(dones), 1);
        check("t4_idx2", 32'(idx), 0);

        // abort after 2 of 5 steps
        div = '0; steps = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("t5_idx2", 32'(idx), 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_pulse", 32'(step_pulse), 0);
        check("t5_idx", 32'(idx), 2);
        step();
        step();
        check("t5_idx_hold", 32'(idx), 2);
        check("t5_done_hold", 32'(done), 0);

        // en=0 freezes a 4-step move, then it resumes
        steps = 16'd4; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t5e_idx3", 32'(idx), 3);
        en = 1'b0;
        step();
        check("t5e_phase_off", 32'(phase), 0);
        check("t5e_pulse_off", 32'(step_pulse), 0);
        step();
        check("t5e_idx_frozen", 32'(idx), 3);
        check("t5e_busy_frozen", 32'(busy), 1);
        en = 1'b1;
        step();
        check("t5e_idx4", 32'(idx), 4);
        check("t5e_phase4", 32'(phase), 32'b100);
        step();
        check("t5e_idx5", 32'(idx), 5);
        step();
        check("t5e_idx0", 32'(idx), 0);
        check("t5e_done", 32'(done), 1);
        check("t5e_busy_end", 32'(busy), 0);

        // asynchronous reset mid-move
        steps = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t6_pre_idx", 32'(idx), 1);
        #2;
        CR = 1'b1;
        #1;
        check("t6_phase", 32'(phase), 0);
        check("t6_idx", 32'(idx), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_pulse", 32'(step_pulse), 0);
        check("t6_done", 32'(done), 0);
        #1;
        CR = 1'b0;
        step();
        check("t6_after_busy", 32'(busy), 0);
        check("t6_after_phase", 32'(phase), 32'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
